decode: RTL and testbench
=========================

Name: decode

Overview:
- Second pipeline stage. Consumes the instruction word and PC produced by the fetch stage through a valid/ready handshake.
- Decodes RV32I fields, reads the register file through combinational read ports, and generates the sign-extended immediate.
- Presents a registered, decoded bundle to the execute stage through a second valid/ready handshake.
- Supports a pipeline flush when a jump (branch/irq/debug) is taken.

Parameters:
- REG_ADDR_W, 5, register-file address width (fixed by the ISA; the parameter exists for lint consistency only).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset: one clock, asynchronous, active-low. Asserted when 0.
- flush_i  input  1  jump taken this cycle (branch/irq/drq); discards in-flight work.
- input_valid_i  input  1  fetch output valid.
- input_ready_o  output  1  decode can accept this cycle.
- instr_i  input  32  instruction word.
- pc_i  input  32  address of instr_i.
- rs1_addr_o  output  5  register-file read port 1 address; combinational, equals instr_i[19:15].
- rs2_addr_o  output  5  register-file read port 2 address; combinational, equals instr_i[24:20].
- rs1_data_i  input  32  read data for rs1_addr_o, same cycle.
- rs2_data_i  input  32  read data for rs2_addr_o, same cycle.
- output_valid_o  output  1  decoded bundle valid.
- output_ready_i  input  1  execute accepts the bundle.
- pc_o  output  32  PC of the decoded instruction.
- op_class_o  output  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL.
- funct3_o  output  3  instr[14:12].
- funct7_5_o  output  1  instr[30].
- rs1_val_o  output  32  latched rs1 data.
- rs2_val_o  output  32  latched rs2 data.
- imm_o  output  32  sign-extended immediate.
- rd_o  output  5  destination register.
- reg_write_o  output  1  1 if the class writes rd and rd != 0.

Behaviour:
- Reset (rst_i=0, asynchronous): output_valid_o=0 and every registered output=0. input_ready_o=1 once reset deasserts.
- Accept condition: input_valid_i && input_ready_o && !flush_i.
- input_ready_o = !output_valid_q || output_ready_i. This is combinational from output_ready_i.
- On accept: decode, then register all bundle fields and set output_valid_o=1 on the next edge. Latency is 1 cycle.
- Output handshake: when output_valid_o && output_ready_i with no new accept, output_valid_o clears on the next edge.
- Hold: when output_valid_o=1 and output_ready_i=0, every output stays stable.
- Immediate formats (sign bit is always instr[31]):
  - I: LOAD, OP_IMM, JALR.
  - S: STORE.
  - B: BRANCH, bit0=0.
  - U: LUI, AUIPC, low 12 bits 0.
  - J: JAL, bit0=0.
  - OP, FENCE, SYSTEM, ILLEGAL: imm_o=0.
- Illegal encodings produce op_class 15, reg_write_o=0, and still pass downstream:
  - unknown opcode[6:0];
  - opcode[1:0] != 2'b11;
  - OP with funct7 other than 0x00 or 0x20;
  - illegal OP/OP_IMM shift funct7.
- reg_write_o=1 for LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP when rd!=0. Otherwise 0.
- flush_i=1: output_valid_o clears on the next edge regardless of output_ready_i. Input offered that cycle is not accepted, and input_ready_o is forced to 0.
- Simultaneous flush_i and output handshake: the flush wins; the bundle is dropped.
- Reset asserted mid-operation: the pending bundle is lost immediately; no partial state survives.

Optional Feature:
- DECODE_SKID_BUFFER_EN defined:
  - Adds a one-entry skid buffer, so input_ready_o is registered: input_ready_o = !skid_valid_q, with no combinational path from output_ready_i.
  - An instruction accepted while the output is stalled goes into the skid entry and moves to the output when the output is consumed.
  - Throughput is 1 per cycle; latency is 1 cycle when not stalled.
  - flush_i clears both entries.
- Undefined: single output register, combinational ready as described above.

Test Plan:
- Reset, then offer ADDI x1,x2,5 = 0x00510093 at pc 0x1000 with rs1_data_i=0x7 -> one cycle later output_valid_o=1, op_class 7, rd_o=1, imm_o=0x5, rs1_val_o=0x7, pc_o=0x1000, reg_write_o=1; rs1_addr_o=2 in the offer cycle.
- LUI x5,0x12345 = 0x123452B7 -> imm_o=0x12345000, op_class 0, rd_o=5. BEQ x0,x0,-4 = 0xFE000EE3 -> op_class 4, imm_o=0xFFFFFFFC, reg_write_o=0.
- Hold output_ready_i=0 for 3 cycles with a valid bundle -> outputs stable, input_ready_o=0 (skid off); release -> bundle consumed once, next instruction accepted the same cycle.
- Assert flush_i with output_valid_o=1 and output_ready_i=1 -> output_valid_o=0 next cycle, the instruction offered during the flush is not accepted.
- Offer 0x00000000 and 0xFFFFFFFF -> op_class 15, reg_write_o=0, output_valid_o=1. ADDI x0,x0,0 (0x00000013) -> reg_write_o=0.
- Drive rst_i low between clock edges while valid -> output_valid_o=0 immediately (before the next edge).

Source files
------------

// File: rtl/decode.sv
// rtl/decode.sv - RV32I decode stage: field decode, regfile read, immediate gen, registered bundle
// Optional DECODE_SKID_BUFFER_EN adds a one-entry skid buffer so input_ready_o is registered.
module decode #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  input_valid_i,
  output logic                  input_ready_o,
  input  logic [31:0]           instr_i,
  input  logic [31:0]           pc_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [31:0]           rs1_data_i,
  input  logic [31:0]           rs2_data_i,
  output logic                  output_valid_o,
  input  logic                  output_ready_i,
  output logic [31:0]           pc_o,
  output logic [3:0]            op_class_o,
  output logic [2:0]            funct3_o,
  output logic                  funct7_5_o,
  output logic [31:0]           rs1_val_o,
  output logic [31:0]           rs2_val_o,
  output logic [31:0]           imm_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic                  reg_write_o
);

  localparam logic [3:0] CLS_LUI     = 4'd0;
  localparam logic [3:0] CLS_AUIPC   = 4'd1;
  localparam logic [3:0] CLS_JAL     = 4'd2;
  localparam logic [3:0] CLS_JALR    = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_LOAD    = 4'd5;
  localparam logic [3:0] CLS_STORE   = 4'd6;
  localparam logic [3:0] CLS_OP_IMM  = 4'd7;
  localparam logic [3:0] CLS_OP      = 4'd8;
  localparam logic [3:0] CLS_FENCE   = 4'd9;
  localparam logic [3:0] CLS_SYSTEM  = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]           pc;
    logic [3:0]            op_class;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic [31:0]           rs1_val;
    logic [31:0]           rs2_val;
    logic [31:0]           imm;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0]  op_class;
  logic [31:0] imm;
  logic        writes_rd;
  logic        accept;
  bundle_t     dec_d;
  bundle_t     out_q;
  logic        out_valid_q;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  assign rs1_addr_o = instr_i[15 +: REG_ADDR_W];
  assign rs2_addr_o = instr_i[20 +: REG_ADDR_W];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  // Exact 7-bit opcode matching also rejects any encoding with opcode[1:0] != 2'b11.
  always_comb begin
    op_class  = CLS_ILLEGAL;
    imm       = 32'h0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI:    begin op_class = CLS_LUI;    imm = imm_u; writes_rd = 1'b1; end
      OPC_AUIPC:  begin op_class = CLS_AUIPC;  imm = imm_u; writes_rd = 1'b1; end
      OPC_JAL:    begin op_class = CLS_JAL;    imm = imm_j; writes_rd = 1'b1; end
      OPC_JALR:   begin op_class = CLS_JALR;   imm = imm_i; writes_rd = 1'b1; end
      OPC_BRANCH: begin op_class = CLS_BRANCH; imm = imm_b; end
      OPC_LOAD:   begin op_class = CLS_LOAD;   imm = imm_i; writes_rd = 1'b1; end
      OPC_STORE:  begin op_class = CLS_STORE;  imm = imm_s; end
      OPC_OP_IMM: begin
        if (!((funct3 == 3'b001 && funct7 != 7'h00) ||
              (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))) begin
          op_class  = CLS_OP_IMM;
          imm       = imm_i;
          writes_rd = 1'b1;
        end
      end
      OPC_OP: begin
        // funct7 0x20 only selects SUB and SRA.
        if ((funct7 == 7'h00) ||
            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          op_class  = CLS_OP;
          writes_rd = 1'b1;
        end
      end
      OPC_FENCE:  op_class = CLS_FENCE;
      OPC_SYSTEM: op_class = CLS_SYSTEM;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

  always_comb begin
    dec_d           = '0;
    dec_d.pc        = pc_i;
    dec_d.op_class  = op_class;
    dec_d.funct3    = funct3;
    dec_d.funct7_5  = instr_i[30];
    dec_d.rs1_val   = rs1_data_i;
    dec_d.rs2_val   = rs2_data_i;
    dec_d.imm       = imm;
    dec_d.rd        = instr_i[7 +: REG_ADDR_W];
    dec_d.reg_write = writes_rd && (instr_i[7 +: REG_ADDR_W] != '0);
  end

`ifdef DECODE_SKID_BUFFER_EN
  bundle_t skid_q;
  logic    skid_valid_q;
  logic    out_free;

  assign input_ready_o = !skid_valid_q && !flush_i;
  assign accept        = input_valid_i && input_ready_o;
  assign out_free      = !out_valid_q || output_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= dec_d;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new instruction so ready need not see output_ready_i.
      skid_q       <= dec_d;
      skid_valid_q <= 1'b1;
    end
  end
`else
  assign input_ready_o = !flush_i && (!out_valid_q || output_ready_i);
  assign accept        = input_valid_i && input_ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec_d;
      out_valid_q <= 1'b1;
    end else if (output_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign output_valid_o = out_valid_q;
  assign pc_o           = out_q.pc;
  assign op_class_o     = out_q.op_class;
  assign funct3_o       = out_q.funct3;
  assign funct7_5_o     = out_q.funct7_5;
  assign rs1_val_o      = out_q.rs1_val;
  assign rs2_val_o      = out_q.rs2_val;
  assign imm_o          = out_q.imm;
  assign rd_o           = out_q.rd;
  assign reg_write_o    = out_q.reg_write;

endmodule

// File: tb/tb_decode.sv
// tb/tb_decode.sv - scoreboard bench for the decode stage
module tb_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [31:0] pc_o;
  logic [3:0]  op_class_o;
  logic [2:0]  funct3_o;
  logic        funct7_5_o;
  logic [31:0] rs1_val_o;
  logic [31:0] rs2_val_o;
  logic [31:0] imm_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;

  decode #(.REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .output_valid_o(output_valid_o), .output_ready_i(output_ready_i),
    .pc_o(pc_o), .op_class_o(op_class_o), .funct3_o(funct3_o), .funct7_5_o(funct7_5_o),
    .rs1_val_o(rs1_val_o), .rs2_val_o(rs2_val_o), .imm_o(imm_o),
    .rd_o(rd_o), .reg_write_o(reg_write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pops   = 0;

  function automatic exp_t mk_exp(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [31:0] r1, input logic [31:0] r2,
                                  input logic [3:0] cls, input logic [31:0] imm, input logic rw);
    exp_t e;
    e.pc = pc; e.cls = cls; e.f3 = ins[14:12]; e.f75 = ins[30];
    e.r1 = r1; e.r2 = r2; e.imm = imm; e.rd = ins[11:7]; e.rw = rw;
    return e;
  endfunction

  // Every bundle handed to execute must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i && output_valid_o && output_ready_i && !flush_i) begin
      exp_t act, e;
      act = '{pc_o, op_class_o, funct3_o, funct7_5_o, rs1_val_o, rs2_val_o, imm_o, rd_o, reg_write_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL bundle_unexpected pc=%h cls=%0d", pc_o, op_class_o);
      end else begin
        e = sb.pop_front();
        pops++;
        if (act !== e) begin
          errors++;
          $display("FAIL bundle got pc=%h cls=%0d f3=%0d f75=%b r1=%h r2=%h imm=%h rd=%0d rw=%b expected pc=%h cls=%0d f3=%0d f75=%b r1=%h r2=%h imm=%h rd=%0d rw=%b",
                   act.pc, act.cls, act.f3, act.f75, act.r1, act.r2, act.imm, act.rd, act.rw,
                   e.pc, e.cls, e.f3, e.f75, e.r1, e.r2, e.imm, e.rd, e.rw);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    input_valid_i = 1'b1;
    instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [3:0] cls, input logic [31:0] imm, input logic rw);
    int n;
    drive(ins, pc, r1, r2);
    n = 0;
    @(negedge clk_i);
    while (!input_ready_o && n < 20) begin
      n++;
      @(negedge clk_i);
    end
    checks++;
    if (!input_ready_o) begin
      errors++;
      $display("FAIL offer_timeout instr=%h ready=%b required 1", ins, input_ready_o);
    end else begin
      sb.push_back(mk_exp(ins, pc, r1, r2, cls, imm, rw));
    end
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    input_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (output_valid_o !== 1'b0 || pc_o !== 32'h0 || imm_o !== 32'h0 || reg_write_o !== 1'b0 || op_class_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b pc=%h imm=%h rw=%b cls=%0d required all 0",
               output_valid_o, pc_o, imm_o, reg_write_o, op_class_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", input_ready_o);
    end
  endtask

  task automatic test_addi();
    output_ready_i = 1'b1;
    @(posedge clk_i); #1;
    drive(32'h00510093, 32'h1000, 32'h7, 32'h0);
    #1;
    checks++;
    if (rs1_addr_o !== 5'd2 || rs2_addr_o !== 5'd5) begin
      errors++;
      $display("FAIL rs_addr got rs1=%0d rs2=%0d required rs1=2 rs2=5", rs1_addr_o, rs2_addr_o);
    end
    offer(32'h00510093, 32'h1000, 32'h7, 32'h0, 4'd7, 32'h5, 1'b1);
    idle();
    checks++;
    if (output_valid_o !== 1'b1 || pc_o !== 32'h1000 || rd_o !== 5'd1) begin
      errors++;
      $display("FAIL addi_latency valid=%b pc=%h rd=%0d required 1 00001000 1", output_valid_o, pc_o, rd_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_formats();
    output_ready_i = 1'b1;
    offer(32'h123452B7, 32'h1004, 32'h11, 32'h22, 4'd0, 32'h12345000, 1'b1);
    offer(32'hFE000EE3, 32'h1008, 32'h0, 32'h0, 4'd4, 32'hFFFFFFFC, 1'b0);
    offer(32'h00512423, 32'h100C, 32'h200, 32'hABCD, 4'd6, 32'h8, 1'b0);
    offer(32'hFF9FF0EF, 32'h1010, 32'h1, 32'h2, 4'd2, 32'hFFFFFFF8, 1'b1);
    offer(32'h402081B3, 32'h1014, 32'h9, 32'h4, 4'd8, 32'h0, 1'b1);
    offer(32'hFFFFF397, 32'h1018, 32'h0, 32'h0, 4'd1, 32'hFFFFF000, 1'b1);
    idle();
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_illegal();
    output_ready_i = 1'b1;
    offer(32'h00000000, 32'h2000, 32'h1, 32'h2, 4'd15, 32'h0, 1'b0);
    offer(32'hFFFFFFFF, 32'h2004, 32'h3, 32'h4, 4'd15, 32'h0, 1'b0);
    offer(32'h022081B3, 32'h2008, 32'h5, 32'h6, 4'd15, 32'h0, 1'b0);
    offer(32'h40209093, 32'h200C, 32'h7, 32'h8, 4'd15, 32'h0, 1'b0);
    offer(32'h00000013, 32'h2010, 32'h0, 32'h0, 4'd7, 32'h0, 1'b0);
    idle();
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_hold();
    int p0;
    output_ready_i = 1'b0;
    offer(32'h00A00113, 32'h3000, 32'h5, 32'h6, 4'd7, 32'hA, 1'b1);
    drive(32'h00100193, 32'h3004, 32'h1, 32'h2);
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (output_valid_o !== 1'b1 || pc_o !== 32'h3000 || imm_o !== 32'hA || rd_o !== 5'd2) begin
        errors++;
        $display("FAIL hold_stable cyc=%0d valid=%b pc=%h imm=%h rd=%0d required 1 00003000 0000000a 2",
                 i, output_valid_o, pc_o, imm_o, rd_o);
      end
`ifndef DECODE_SKID_BUFFER_EN
      checks++;
      if (input_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_ready cyc=%0d got %b required 0", i, input_ready_o);
      end
`endif
    end
    @(posedge clk_i); #1;
    output_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (input_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b required 1", input_ready_o);
    end else begin
      sb.push_back(mk_exp(32'h00100193, 32'h3004, 32'h1, 32'h2, 4'd7, 32'h1, 1'b1));
    end
    @(posedge clk_i); #1;
    idle();
    checks++;
    if (pops !== p0 + 1 || output_valid_o !== 1'b1 || pc_o !== 32'h3004) begin
      errors++;
      $display("FAIL release_once pops=%0d valid=%b pc=%h required pops=%0d 1 00003004",
               pops - p0, output_valid_o, pc_o, 1);
    end
    repeat (2) @(posedge clk_i); #1;
  endtask

  task automatic test_flush();
    output_ready_i = 1'b1;
    offer(32'h00700213, 32'h4000, 32'h0, 32'h0, 4'd7, 32'h7, 1'b1);
    drive(32'h00800293, 32'h4004, 32'h0, 32'h0);
    flush_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (input_ready_o !== 1'b0 || output_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_cycle ready=%b valid=%b required 0 1", input_ready_o, output_valid_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    idle();
    if (sb.size() > 0) void'(sb.pop_front());
    checks++;
    if (output_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop valid=%b required 0", output_valid_o);
    end
    @(negedge clk_i);
    checks++;
    if (output_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept valid=%b pc=%h required 0", output_valid_o, pc_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_async_reset();
    output_ready_i = 1'b0;
    offer(32'h00900313, 32'h5000, 32'h3, 32'h4, 4'd7, 32'h9, 1'b1);
    idle();
    #2;
    rst_i = 1'b0;
    #1;
    checks++;
    if (output_valid_o !== 1'b0 || pc_o !== 32'h0 || rd_o !== 5'd0 || imm_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset valid=%b pc=%h rd=%0d imm=%h required all 0", output_valid_o, pc_o, rd_o, imm_o);
    end
    sb.delete();
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    output_ready_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (input_ready_o !== 1'b1 || output_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset ready=%b valid=%b required 1 0", input_ready_o, output_valid_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    output_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ins;
      ins = {12'(i * 3), 5'd1, 3'b000, 5'(i + 1), 7'b0010011};
      offer(ins, 32'h6000 + 32'(i * 4), 32'(i), 32'(i + 100), 4'd7, 32'(i * 3), 1'b1);
    end
    idle();
    repeat (3) @(posedge clk_i); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required 0", sb.size());
    end
  endtask

  initial begin
    flush_i = 1'b0; input_valid_i = 1'b0; output_ready_i = 1'b1;
    instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
    test_reset();
    test_addi();
    test_formats();
    test_illegal();
    test_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
